lsq_mem_port: RTL and testbench

- Memory-side consumer of the Load/Store Queue issue interface. Accepts one issued LSQ entry at a time and performs the word access against the data cache.
- Sequences cache misses through refill and replay, and broadcasts completion (load data or store-done) to the ROB/CDB.
- Drives DMISS back to the LSQ as the issue-blocking signal.

---
 rtl/lsq_mem_port_if.sv | 48 ++++
 rtl/lsq_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_lsq_mem_port.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : lsq_mem_port_if
// Purpose  : LSQ issue, data-cache and CDB signal bundle for lsq_mem_port.
// Revision : 1.0  initial release
// ============================================================================
interface lsq_mem_port_if #(
    parameter int ENTRY_W = 192,
    parameter int ROB_W   = 6,
    parameter int TAG_W   = 6
);
    // LSQ issue side
    logic               do_issue;
    logic [ENTRY_W-1:0] data_in;
    logic               DMISS;

    // data cache side
    logic               dc_req;
    logic               dc_we;
    logic [31:0]        dc_addr;
    logic [31:0]        dc_wdata;
    logic               dc_hit;
    logic               dc_miss;
    logic [31:0]        dc_rdata;
    logic               dc_fill_done;

    // completion broadcast
    logic               cdb_valid;
    logic [ROB_W-1:0]   cdb_rob;
    logic [TAG_W-1:0]   cdb_tag;
    logic [31:0]        cdb_data;
    logic               cdb_is_load;

    // master: the LSQ/cache/ROB environment around the port
    modport master (
        output do_issue, data_in, dc_hit, dc_miss, dc_rdata, dc_fill_done,
        input  DMISS, dc_req, dc_we, dc_addr, dc_wdata,
               cdb_valid, cdb_rob, cdb_tag, cdb_data, cdb_is_load
    );

    // slave: the memory port itself
    modport slave (
        input  do_issue, data_in, dc_hit, dc_miss, dc_rdata, dc_fill_done,
        output DMISS, dc_req, dc_we, dc_addr, dc_wdata,
               cdb_valid, cdb_rob, cdb_tag, cdb_data, cdb_is_load
    );
endinterface
`default_nettype wire

// File: rtl/lsq_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsq_mem_port
// Purpose  : Executes one issued LSQ entry against the D-cache, replays misses
//            after refill and broadcasts completion on the CDB.
// Revision : 1.0  initial release
// ============================================================================
module lsq_mem_port #(
    parameter int ENTRY_W = 192,
    parameter int ROB_W   = 6,
    parameter int TAG_W   = 6,
    parameter int CNT_W   = 16
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    input  wire logic             FREEZE,
    input  wire logic             mispredict,
    input  wire logic             flush_fCOM,
    lsq_mem_port_if.slave         bus,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACCESS    = 3'd1,
        S_MISS_WAIT = 3'd2,
        S_WB        = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    localparam int c_VALID_BIT = 191;
    localparam int c_ROB_LSB   = 154;
    localparam int c_TAG_LSB   = 142;
    localparam int c_RD_BIT    = 135;
    localparam int c_WR_BIT    = 133;

    state_t             state_q, state_d;
    logic               dmiss_q, dmiss_d;
    logic [ROB_W-1:0]   rob_q, rob_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               is_load_q, is_load_d;
    logic               we_q, we_d;
    logic [31:2]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic w_flush;
    logic w_run;
    logic w_accept;
    logic w_rd;
    logic w_wr;
    logic w_req;
    logic w_cdb_fire;

    logic unused_entry_bits;
    assign unused_entry_bits = ^{bus.data_in[ENTRY_W-2:160], bus.data_in[153:148],
                                 bus.data_in[141:136], bus.data_in[134],
                                 bus.data_in[132:64], bus.data_in[33:32]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
    endfunction

    assign w_flush  = mispredict | flush_fCOM;
    assign w_run    = ~w_flush & ~FREEZE;
    assign w_rd     = bus.data_in[c_RD_BIT];
    assign w_wr     = bus.data_in[c_WR_BIT];
    assign w_accept = bus.do_issue & bus.data_in[c_VALID_BIT] & (w_rd | w_wr);

    assign w_req      = (state_q == S_ACCESS) & w_run;
    assign w_cdb_fire = (state_q == S_WB) & w_run;

    always_comb begin
        state_d    = state_q;
        rob_d      = rob_q;
        tag_d      = tag_q;
        is_load_d  = is_load_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_run && w_accept) begin
                    rob_d     = bus.data_in[c_ROB_LSB +: ROB_W];
                    tag_d     = bus.data_in[c_TAG_LSB +: TAG_W];
                    is_load_d = w_rd & ~w_wr;
                    we_d      = w_wr;
                    addr_d    = bus.data_in[63:34];
                    wdata_d   = w_wr ? bus.data_in[31:0] : 32'd0;
                    rdata_d   = 32'd0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_flush) begin
                    state_d = S_IDLE;
                end else if (!FREEZE) begin
                    // a simultaneous hit+miss is resolved as a hit
                    if (bus.dc_hit) begin
                        rdata_d   = is_load_q ? bus.dc_rdata : 32'd0;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                        state_d   = S_WB;
                    end else if (bus.dc_miss) begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = S_MISS_WAIT;
                    end
                end
            end
            S_MISS_WAIT: begin
                if (w_flush) begin
                    state_d = bus.dc_fill_done ? S_IDLE : S_DRAIN;
                end else if (!FREEZE && bus.dc_fill_done) begin
                    state_d = S_ACCESS;
                end
            end
            S_WB: begin
                if (w_flush || !FREEZE) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // the outstanding refill must still be absorbed while flushing
                if (bus.dc_fill_done && (w_flush || !FREEZE)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        dmiss_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            dmiss_q    <= 1'b0;
            rob_q      <= '0;
            tag_q      <= '0;
            is_load_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dmiss_q    <= dmiss_d;
            rob_q      <= rob_d;
            tag_q      <= tag_d;
            is_load_q  <= is_load_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.DMISS       = dmiss_q;
    assign bus.dc_req      = w_req;
    assign bus.dc_we       = w_req & we_q;
    assign bus.dc_addr     = w_req ? {addr_q, 2'b00} : 32'd0;
    assign bus.dc_wdata    = w_req ? wdata_q : 32'd0;

    assign bus.cdb_valid   = w_cdb_fire;
    assign bus.cdb_rob     = w_cdb_fire ? rob_q : '0;
    assign bus.cdb_tag     = (w_cdb_fire && is_load_q) ? tag_q : '0;
    assign bus.cdb_data    = w_cdb_fire ? rdata_q : 32'd0;
    assign bus.cdb_is_load = w_cdb_fire & is_load_q;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lsq_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_mem_port
// Purpose  : Cycle-table bench for lsq_mem_port (4-bit counters to reach
//            saturation quickly). Revision : 1.0
// ============================================================================
module tb_lsq_mem_port;

    localparam int ENTRY_W = 192;
    localparam int ROB_W   = 6;
    localparam int TAG_W   = 6;
    localparam int CNT_W   = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic FREEZE;
    logic mispredict;
    logic flush_fCOM;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    lsq_mem_port_if #(.ENTRY_W(ENTRY_W), .ROB_W(ROB_W), .TAG_W(TAG_W)) bus ();

    lsq_mem_port #(.ENTRY_W(ENTRY_W), .ROB_W(ROB_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FREEZE     (FREEZE),
        .mispredict (mispredict),
        .flush_fCOM (flush_fCOM),
        .bus        (bus),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 CLK = ~CLK;

    // one record = inputs driven for one cycle + outputs expected in that cycle
    typedef struct {
        logic        issue, vld, rd, wr;
        logic [5:0]  rob, tag;
        logic [31:0] addr, wdata;
        logic        hit, miss, fill, frz, fl;
        logic [31:0] rdata;
        logic        e_dmiss, e_req, e_we, e_cv, e_ld;
        logic [31:0] e_addr, e_wdata, e_data;
        logic [5:0]  e_rob, e_tag;
        logic [3:0]  e_hit, e_miss;
    } vec_t;

    vec_t tbl[$];
    int   h_exp;
    int   m_exp;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t blank(input logic dm);
        vec_t v;
        v = '{default: '0};
        v.e_dmiss = dm;
        v.e_hit   = 4'(h_exp);
        v.e_miss  = 4'(m_exp);
        return v;
    endfunction

    function automatic vec_t with_issue(input vec_t vi, input logic vld, input logic rd, input logic wr,
                                        input logic [5:0] rob, input logic [5:0] tag,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v = vi;
        v.issue = 1'b1; v.vld = vld; v.rd = rd; v.wr = wr;
        v.rob = rob; v.tag = tag; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    function automatic vec_t with_acc(input vec_t vi, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata);
        vec_t v = vi;
        v.e_req = 1'b1; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata;
        return v;
    endfunction

    function automatic vec_t with_resp(input vec_t vi, input logic hit, input logic miss,
                                       input logic [31:0] rdata);
        vec_t v = vi;
        v.hit = hit; v.miss = miss; v.rdata = rdata;
        return v;
    endfunction

    function automatic vec_t with_wb(input vec_t vi, input logic [5:0] rob, input logic [5:0] tag,
                                     input logic [31:0] data, input logic ld);
        vec_t v = vi;
        v.e_cv = 1'b1; v.e_rob = rob; v.e_tag = tag; v.e_data = data; v.e_ld = ld;
        return v;
    endfunction

    function automatic vec_t with_flags(input vec_t vi, input logic frz, input logic fl, input logic fill);
        vec_t v = vi;
        v.frz = frz; v.fl = fl; v.fill = fill;
        return v;
    endfunction

    // unused entry bits are set to 1 so a mis-decoded field shows up
    function automatic logic [ENTRY_W-1:0] mk_entry(input vec_t v);
        logic [ENTRY_W-1:0] e;
        e = {ENTRY_W{1'b1}};
        e[191]     = v.vld;
        e[159:154] = v.rob;
        e[147:142] = v.tag;
        e[135]     = v.rd;
        e[133]     = v.wr;
        e[63:32]   = v.addr;
        e[31:0]    = v.wdata;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        bus.do_issue     = v.issue;
        bus.data_in      = v.issue ? mk_entry(v) : '0;
        bus.dc_hit       = v.hit;
        bus.dc_miss      = v.miss;
        bus.dc_rdata     = v.rdata;
        bus.dc_fill_done = v.fill;
        FREEZE           = v.frz;
        mispredict       = v.fl;
        flush_fCOM       = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge CLK);
        drive(v);
        #2;
        chk("DMISS",       idx, 32'(bus.DMISS),       32'(v.e_dmiss));
        chk("dc_req",      idx, 32'(bus.dc_req),      32'(v.e_req));
        chk("dc_we",       idx, 32'(bus.dc_we),       32'(v.e_we));
        chk("dc_addr",     idx, bus.dc_addr,          v.e_addr);
        chk("dc_wdata",    idx, bus.dc_wdata,         v.e_wdata);
        chk("cdb_valid",   idx, 32'(bus.cdb_valid),   32'(v.e_cv));
        chk("cdb_rob",     idx, 32'(bus.cdb_rob),     32'(v.e_rob));
        chk("cdb_tag",     idx, 32'(bus.cdb_tag),     32'(v.e_tag));
        chk("cdb_data",    idx, bus.cdb_data,         v.e_data);
        chk("cdb_is_load", idx, 32'(bus.cdb_is_load), 32'(v.e_ld));
        chk("hit_cnt",     idx, 32'(hit_cnt),         32'(v.e_hit));
        chk("miss_cnt",    idx, 32'(miss_cnt),        32'(v.e_miss));
    endtask

    task automatic check_all_zero(input int idx);
        chk("rst DMISS",     idx, 32'(bus.DMISS),     32'd0);
        chk("rst dc_req",    idx, 32'(bus.dc_req),    32'd0);
        chk("rst dc_we",     idx, 32'(bus.dc_we),     32'd0);
        chk("rst dc_addr",   idx, bus.dc_addr,        32'd0);
        chk("rst dc_wdata",  idx, bus.dc_wdata,       32'd0);
        chk("rst cdb_valid", idx, 32'(bus.cdb_valid), 32'd0);
        chk("rst cdb_rob",   idx, 32'(bus.cdb_rob),   32'd0);
        chk("rst cdb_tag",   idx, 32'(bus.cdb_tag),   32'd0);
        chk("rst cdb_data",  idx, bus.cdb_data,       32'd0);
        chk("rst hit_cnt",   idx, 32'(hit_cnt),       32'd0);
        chk("rst miss_cnt",  idx, 32'(miss_cnt),      32'd0);
    endtask

    function automatic void sat_hit();
        if (h_exp < 15) h_exp++;
    endfunction

    function automatic void sat_miss();
        if (m_exp < 15) m_exp++;
    endfunction

    initial begin
        RESET = 1'b0;
        drive('{default: '0});
        h_exp = 0;
        m_exp = 0;
        #2;
        check_all_zero(-1);

        // load hit
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd5, 6'd9, 32'h100, 32'h0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h100, 0), 1, 0, 32'hDEADBEEF)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd5, 6'd9, 32'hDEADBEEF, 1));
        // store miss, refill, replay hit
        tbl.push_back(with_issue(blank(0), 1, 0, 1, 6'd3, 6'd7, 32'h203, 32'h55));
        tbl.push_back(with_resp(with_acc(blank(1), 1, 32'h200, 32'h55), 0, 1, 32'h0)); sat_miss();
        tbl.push_back(blank(1));
        tbl.push_back(with_flags(blank(1), 0, 0, 1));
        tbl.push_back(with_resp(with_acc(blank(1), 1, 32'h200, 32'h55), 1, 0, 32'hFFFF)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd3, 6'd0, 32'h0, 0));
        // ignored entries
        tbl.push_back(with_issue(blank(0), 0, 1, 0, 6'd1, 6'd1, 32'h4, 32'h0));
        tbl.push_back(with_issue(blank(0), 1, 0, 0, 6'd1, 6'd1, 32'h4, 32'h0));
        // freeze three cycles in WB
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd1, 6'd2, 32'h44, 32'h0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h44, 0), 1, 0, 32'h12345678)); sat_hit();
        for (int i = 0; i < 3; i++) tbl.push_back(with_flags(blank(1), 1, 0, 0));
        tbl.push_back(with_wb(blank(1), 6'd1, 6'd2, 32'h12345678, 1));
        // freeze one cycle in ACCESS
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd2, 6'd3, 32'h8, 32'h0));
        tbl.push_back(with_flags(blank(1), 1, 0, 0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h8, 0), 1, 0, 32'hA5)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd2, 6'd3, 32'hA5, 1));
        // flush in ACCESS, then flush blocks an IDLE accept
        tbl.push_back(with_issue(blank(0), 1, 0, 1, 6'd4, 6'd0, 32'h10, 32'hAA));
        tbl.push_back(with_flags(blank(1), 0, 1, 0));
        tbl.push_back(with_flags(with_issue(blank(0), 1, 1, 0, 6'd4, 6'd4, 32'h14, 32'h0), 0, 1, 0));
        // flush in WB suppresses the broadcast
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd6, 6'd1, 32'h20, 32'h0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h20, 0), 1, 0, 32'h77)); sat_hit();
        tbl.push_back(with_flags(blank(1), 0, 1, 0));
        // flush in MISS_WAIT, refill arrives four cycles later
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd7, 6'd8, 32'h30, 32'h0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h30, 0), 0, 1, 32'h0)); sat_miss();
        tbl.push_back(with_flags(blank(1), 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(blank(1));
        tbl.push_back(with_flags(blank(1), 0, 0, 1));
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd10, 6'd11, 32'h40, 32'h0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h40, 0), 1, 0, 32'hCAFE)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd10, 6'd11, 32'hCAFE, 1));
        // flush in MISS_WAIT together with fill_done goes straight to IDLE
        tbl.push_back(with_issue(blank(0), 1, 0, 1, 6'd12, 6'd5, 32'h50, 32'h1));
        tbl.push_back(with_resp(with_acc(blank(1), 1, 32'h50, 32'h1), 0, 1, 32'h0)); sat_miss();
        tbl.push_back(with_flags(blank(1), 0, 1, 1));
        // illegal hit+miss is a hit; unaligned load address; load wdata ignored
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd13, 6'd14, 32'h63, 32'hFFFF));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h60, 0), 1, 1, 32'h99)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd13, 6'd14, 32'h99, 1));
        // no response keeps re-requesting
        tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd15, 6'd16, 32'h70, 32'h0));
        tbl.push_back(with_acc(blank(1), 0, 32'h70, 0));
        tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h70, 0), 1, 0, 32'h3)); sat_hit();
        tbl.push_back(with_wb(blank(1), 6'd15, 6'd16, 32'h3, 1));
        // counter saturation
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(with_issue(blank(0), 1, 1, 0, 6'd20, 6'd21, 32'h80, 32'h0));
            tbl.push_back(with_resp(with_acc(blank(1), 0, 32'h80, 0), 1, 0, 32'h5)); sat_hit();
            tbl.push_back(with_wb(blank(1), 6'd20, 6'd21, 32'h5, 1));
        end
        for (int i = 0; i < 14; i++) begin
            tbl.push_back(with_issue(blank(0), 1, 0, 1, 6'd22, 6'd0, 32'h90, 32'h2));
            tbl.push_back(with_resp(with_acc(blank(1), 1, 32'h90, 32'h2), 0, 1, 32'h0)); sat_miss();
            tbl.push_back(with_flags(blank(1), 0, 1, 1));
        end
        tbl.push_back(blank(0));

        @(negedge CLK);
        RESET = 1'b1;
        foreach (tbl[i]) apply(tbl[i], i);

        // reset asserted mid-ACCESS clears everything without a clock edge
        apply(with_issue(blank(0), 1, 1, 0, 6'd30, 6'd31, 32'hA0, 32'h0), 1000);
        apply(with_acc(blank(1), 0, 32'hA0, 0), 1001);
        #1;
        RESET = 1'b0;
        #1;
        check_all_zero(1002);
        @(negedge CLK);
        RESET = 1'b1;
        h_exp = 0;
        m_exp = 0;
        apply(with_issue(blank(0), 1, 1, 0, 6'd1, 6'd2, 32'hB0, 32'h0), 1003);
        apply(with_resp(with_acc(blank(1), 0, 32'hB0, 0), 1, 0, 32'h42), 1004); sat_hit();
        apply(with_wb(blank(1), 6'd1, 6'd2, 32'h42, 1), 1005);
        apply(blank(0), 1006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
